// File: rtl/neurasic_pkg.sv
// Shared fixed-point definitions for the neuron lane: precisions, the
// sequencing state enum and the signed saturate/truncate helper.
package neurasic_pkg;

    localparam int XDATA_PREC = 5;
    localparam int WDATA_PREC = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Reduce v to a signed width-bit value (clamped or wrapped), sign-extended back to 64 bits.
    function automatic logic signed [63:0] sat_trunc(
        input logic signed [63:0] v,
        input int                 width,
        input logic               sat
    );
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] result;
        max_v  = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v  = -max_v - 64'sd1;
        result = (v <<< (64 - width)) >>> (64 - width);
        if (sat) begin
            if (v > max_v) begin
                result = max_v;
            end else if (v < min_v) begin
                result = min_v;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fxp_mul_shift.sv
// Signed fixed-point multiply with arithmetic right shift and output reduction.
// Saturates when NEURON_GRAD_SAT_EN is defined, otherwise wraps.
module fxp_mul_shift
    import neurasic_pkg::*;
#(
    parameter int A_WIDTH   = 10,
    parameter int B_WIDTH   = 11,
    parameter int SHIFT     = 5,
    parameter int OUT_WIDTH = 10
) (
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic [OUT_WIDTH-1:0] p
);

`ifdef NEURON_GRAD_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam int PW = A_WIDTH + B_WIDTH;

    logic signed [PW-1:0] prod;
    logic signed [63:0]   shifted;
    logic signed [63:0]   reduced;
    logic                 unused_hi;

    assign prod    = $signed(a) * $signed(b);
    // Shift in 64 bits so the flooring >>> sees the full sign-extended product.
    assign shifted = $signed({{(64 - PW){prod[PW-1]}}, prod}) >>> SHIFT;
    assign reduced = sat_trunc(shifted, OUT_WIDTH, SAT_EN);
    assign p       = reduced[OUT_WIDTH-1:0];
    assign unused_hi = ^reduced[63:OUT_WIDTH];

endmodule

// File: rtl/neuron_grad.sv
// ReLU neuron backward pass: per-sample dL/dx plus batch sums of dL/dw and dL/db.
// NEURON_GRAD_SAT_EN selects saturating (sticky) arithmetic instead of wrap.
module neuron_grad
    import neurasic_pkg::*;
#(
    parameter int XDATA_WIDTH = 10,
    parameter int WDATA_WIDTH = 11,
    parameter int XDATA_PREC_P = XDATA_PREC,
    parameter int WDATA_PREC_P = WDATA_PREC,
    parameter int ACC_WIDTH   = 24,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   batch_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XDATA_WIDTH-1:0] in_x,
    input  logic [WDATA_WIDTH-1:0] in_w,
    input  logic [XDATA_WIDTH-1:0] in_y,
    input  logic [XDATA_WIDTH-1:0] in_gy,
    output logic                   gx_valid,
    input  logic                   gx_ready,
    output logic [XDATA_WIDTH-1:0] gx,
    output logic                   grad_valid,
    input  logic                   grad_ready,
    output logic [ACC_WIDTH-1:0]   grad_w,
    output logic [ACC_WIDTH-1:0]   grad_b,
    output logic                   busy
);

`ifdef NEURON_GRAD_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam int TW = 2 * XDATA_WIDTH;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, len_reg;
    logic [ACC_WIDTH-1:0]   acc_w_reg, acc_b_reg;
    logic                   stick_w_reg, stick_b_reg;
    logic [XDATA_WIDTH-1:0] gx_reg;
    logic                   gx_valid_reg;

    logic                   accept;
    logic                   last_accept;
    logic [XDATA_WIDTH-1:0] g;
    logic [XDATA_WIDTH-1:0] gx_calc;
    logic signed [TW-1:0]   term_w;
    logic signed [63:0]     sum_w, sum_b, red_w, red_b;
    logic                   hit_w, hit_b;
    logic                   unused_hi;

    // ReLU derivative: only strictly positive activations pass the gradient.
    assign g = ($signed(in_y) > 0) ? in_gy : '0;

    fxp_mul_shift #(
        .A_WIDTH   (XDATA_WIDTH),
        .B_WIDTH   (WDATA_WIDTH),
        .SHIFT     (WDATA_PREC_P),
        .OUT_WIDTH (XDATA_WIDTH)
    ) u_gx_mul (
        .a (g),
        .b (in_w),
        .p (gx_calc)
    );

    assign term_w = $signed(g) * $signed(in_x);
    assign sum_w  = 64'($signed(acc_w_reg)) + 64'(term_w);
    assign sum_b  = 64'($signed(acc_b_reg)) + 64'($signed(g));
    assign red_w  = sat_trunc(sum_w, ACC_WIDTH, SAT_EN);
    assign red_b  = sat_trunc(sum_b, ACC_WIDTH, SAT_EN);
    assign hit_w  = SAT_EN && (red_w != sum_w);
    assign hit_b  = SAT_EN && (red_b != sum_b);
    assign unused_hi = ^{red_w[63:ACC_WIDTH], red_b[63:ACC_WIDTH]};

    assign in_ready    = (state_reg == ACCUM) && (!gx_valid_reg || gx_ready);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (CNT_WIDTH'(cnt_reg + 1'b1) == len_reg);

    assign gx_valid   = gx_valid_reg;
    assign gx         = gx_reg;
    assign grad_valid = (state_reg == DONE);
    assign grad_w     = acc_w_reg;
    assign grad_b     = acc_b_reg;
    assign busy       = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (batch_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_accept) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (grad_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            len_reg     <= '0;
            acc_w_reg   <= '0;
            acc_b_reg   <= '0;
            stick_w_reg <= 1'b0;
            stick_b_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            cnt_reg     <= '0;
            len_reg     <= batch_len;
            acc_w_reg   <= '0;
            acc_b_reg   <= '0;
            stick_w_reg <= 1'b0;
            stick_b_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
            // Once an accumulator clamps it holds its limit until the next batch.
            if (!stick_w_reg) begin
                acc_w_reg   <= red_w[ACC_WIDTH-1:0];
                stick_w_reg <= hit_w;
            end
            if (!stick_b_reg) begin
                acc_b_reg   <= red_b[ACC_WIDTH-1:0];
                stick_b_reg <= hit_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_reg       <= '0;
            gx_valid_reg <= 1'b0;
        end else if (accept) begin
            gx_reg       <= gx_calc;
            gx_valid_reg <= 1'b1;
        end else if (gx_ready) begin
            gx_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neuron_grad.sv
// Directed self-checking bench for neuron_grad: single-sample vector table
// plus hand-written stall, zero-length and mid-batch reset sequences.
module tb_neuron_grad;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  batch_len;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [10:0] in_w;
    logic [9:0]  in_y;
    logic [9:0]  in_gy;
    logic        gx_valid;
    logic        gx_ready;
    logic [9:0]  gx;
    logic        grad_valid;
    logic        grad_ready;
    logic [23:0] grad_w;
    logic [23:0] grad_b;
    logic        busy;

    int checks = 0;
    int passed = 0;

    neuron_grad dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .batch_len  (batch_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_w       (in_w),
        .in_y       (in_y),
        .in_gy      (in_gy),
        .gx_valid   (gx_valid),
        .gx_ready   (gx_ready),
        .gx         (gx),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_w     (grad_w),
        .grad_b     (grad_b),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int w;
        int y;
        int gy;
        int exp_gx;
        int exp_gw;
        int exp_gb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_single(input int i);
        batch_len = 8'd1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("single_busy", busy, 1);
        chk("single_in_ready", in_ready, 1);
        in_x     = 10'(vecs[i].x);
        in_w     = 11'(vecs[i].w);
        in_y     = 10'(vecs[i].y);
        in_gy    = 10'(vecs[i].gy);
        in_valid = 1'b1;
        gx_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("single_gx_valid", gx_valid, 1);
        chk("single_gx", $signed(gx), vecs[i].exp_gx);
        chk("single_grad_valid", grad_valid, 1);
        chk("single_grad_w", $signed(grad_w), vecs[i].exp_gw);
        chk("single_grad_b", $signed(grad_b), vecs[i].exp_gb);
        grad_ready = 1'b1;
        @(posedge clk); #1;
        grad_ready = 1'b0;
        chk("single_idle_busy", busy, 0);
        chk("single_idle_grad_valid", grad_valid, 0);
        chk("single_idle_gx_valid", gx_valid, 0);
        $display("single vec %0d: gx=%0d grad_w=%0d grad_b=%0d", i, vecs[i].exp_gx, vecs[i].exp_gw, vecs[i].exp_gb);
    endtask

    initial begin
        int gys[3];
        int exp_gx_q[3];
        int k;
        int hs;
        int stall_seen;

        vecs[0] = '{x: 64,  w: 48,   y: 10, gy: 32,  exp_gx: 48,  exp_gw: 2048, exp_gb: 32};
        vecs[1] = '{x: 64,  w: 48,   y: 0,  gy: 32,  exp_gx: 0,   exp_gw: 0,    exp_gb: 0};
`ifdef NEURON_GRAD_SAT_EN
        vecs[2] = '{x: 0,   w: 1023, y: 1,  gy: 511, exp_gx: 511, exp_gw: 0,    exp_gb: 511};
`else
        vecs[2] = '{x: 0,   w: 1023, y: 1,  gy: 511, exp_gx: -48, exp_gw: 0,    exp_gb: 511};
`endif
        vecs[3] = '{x: -64, w: 48,   y: 5,  gy: -32, exp_gx: -48, exp_gw: 2048, exp_gb: -32};
        vecs[4] = '{x: 64,  w: 48,   y: -3, gy: 32,  exp_gx: 0,   exp_gw: 0,    exp_gb: 0};
        vecs[5] = '{x: 1,   w: 1,    y: 1,  gy: -1,  exp_gx: -1,  exp_gw: -1,   exp_gb: -1};

        rst_n = 1'b0; start = 1'b0; batch_len = '0; in_valid = 1'b0;
        in_x = '0; in_w = '0; in_y = '0; in_gy = '0; gx_ready = 1'b0; grad_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_gx_valid", gx_valid, 0);
        chk("rst_gx", gx, 0);
        chk("rst_grad_valid", grad_valid, 0);
        chk("rst_grad_w", grad_w, 0);
        chk("rst_grad_b", grad_b, 0);
        chk("rst_busy", busy, 0);
        $display("reset state checked");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // in_valid while idle must not be accepted
        in_valid = 1'b1; in_x = 10'd64; in_w = 11'd48; in_y = 10'd10; in_gy = 10'd32;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("idle_no_accept_gx_valid", gx_valid, 0);
        chk("idle_in_ready", in_ready, 0);
        $display("idle in_valid ignored");

        for (int i = 0; i < 6; i++) begin
            run_single(i);
        end

        // batch of 3 with gx_ready toggling
        gys[0] = 32; gys[1] = 32; gys[2] = -32;
        exp_gx_q[0] = 32; exp_gx_q[1] = 32; exp_gx_q[2] = -32;
        k = 0; hs = 0; stall_seen = 0;
        batch_len = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (k < 3) begin
                in_valid = 1'b1; in_x = 10'd32; in_w = 11'd32; in_y = 10'd7; in_gy = 10'(gys[k]);
            end else begin
                in_valid = 1'b0;
            end
            gx_ready = (cyc % 2 == 0);
            #1;
            if (gx_valid && !gx_ready) begin
                chk("stall_in_ready", in_ready, 0);
                stall_seen++;
            end
            if (gx_valid && gx_ready) begin
                if (hs < 3) chk("batch3_gx", $signed(gx), exp_gx_q[hs]);
                $display("batch3 gx handshake %0d value %0d", hs, $signed(gx));
                hs++;
            end
            if (in_valid && in_ready) k++;
            if (grad_valid && hs >= 3) break;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("batch3_handshakes", hs, 3);
        chk("batch3_stall_seen", stall_seen != 0, 1);
        chk("batch3_grad_valid", grad_valid, 1);
        chk("batch3_grad_w", $signed(grad_w), 1024);
        chk("batch3_grad_b", $signed(grad_b), 32);
        grad_ready = 1'b1; gx_ready = 1'b1;
        @(posedge clk); #1;
        grad_ready = 1'b0;
        chk("batch3_idle_busy", busy, 0);
        chk("batch3_idle_gx_valid", gx_valid, 0);
        $display("batch3: grad_w=%0d grad_b=%0d handshakes=%0d", $signed(grad_w), $signed(grad_b), hs);

        // zero-length batch; start while busy must be ignored
        batch_len = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_grad_valid", grad_valid, 1);
        chk("zero_grad_w", grad_w, 0);
        chk("zero_grad_b", grad_b, 0);
        for (int c = 0; c < 5; c++) begin
            batch_len = 8'd3; start = 1'b1;
            @(posedge clk); #1;
            chk("zero_hold_valid", grad_valid, 1);
            chk("zero_hold_w", grad_w, 0);
            chk("zero_hold_b", grad_b, 0);
            chk("zero_hold_in_ready", in_ready, 0);
        end
        start = 1'b0;
        grad_ready = 1'b1;
        @(posedge clk); #1;
        grad_ready = 1'b0;
        chk("zero_idle_busy", busy, 0);
        $display("zero-length batch held 5 cycles");

        // reset after 2 of 4 samples
        batch_len = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_x = 10'd64; in_w = 11'd48; in_y = 10'd10; in_gy = 10'd32; gx_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_grad_w", $signed(grad_w), 4096);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_gx_valid", gx_valid, 0);
        chk("midrst_gx", gx, 0);
        chk("midrst_grad_valid", grad_valid, 0);
        chk("midrst_grad_w", grad_w, 0);
        chk("midrst_grad_b", grad_b, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_grad_valid", grad_valid, 0);
        $display("mid-batch reset cleared outputs");
        run_single(0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
